slider_move_ctrl: RTL and testbench
===================================

SLIDER_MOVE_CTRL -- requirements
Module: slider_move_ctrl

Interface
REQ-001 SHALL have parameter SPECIAL_FRAMES, default 180: frames the slow-move (special block) window lasts.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 600: frames without player keys before autopilot handover.
REQ-003 SHALL have ports (clock and reset first):
- iVGA_CLK  in  1  sole clock
- iRST_n  in  1  synchronous active-low reset
- iFrame_tick  in  1  one-cycle pulse, once per frame
- iKey_go / iKey_back / iKey_up / iKey_down  in  1 each  player direction levels
- iAuto_en  in  1  autopilot enable level
- iAuto_go / iAuto_back / iAuto_up / iAuto_down  in  1 each  autopilot direction levels
- iSpecial_hit  in  1  one-cycle pulse, special block struck
- oSlider_go / oSlider_back / oSlider_up / oSlider_down  out  1 each  one-cycle move strobes to slider datapath
- oSpecial_block  out  1  slow-move window active
- oOwner  out  1  0 = player, 1 = autopilot
- oState  out  2  FSM state: 00 IDLE, 01 PLAYER, 10 AUTO

Function
REQ-004 SHALL implement FSM with states IDLE, PLAYER, AUTO; code 11 unreachable, SHALL recover to IDLE on next cycle.
REQ-005 "Player active" SHALL mean any iKey_* high in the current cycle.
REQ-006 Any state with player active SHALL transition to PLAYER on next edge; player input has absolute priority over autopilot.
REQ-007 SHALL keep 10-bit idle counter: clears when player active; else increments on iFrame_tick; saturates at IDLE_TIMEOUT.
REQ-008 PLAYER or IDLE, idle counter == IDLE_TIMEOUT, iAuto_en high, player inactive SHALL transition to AUTO.
REQ-009 PLAYER, idle counter == IDLE_TIMEOUT, iAuto_en low SHALL transition to IDLE.
REQ-010 AUTO with iAuto_en low and player inactive SHALL transition to IDLE next edge.
REQ-011 oOwner SHALL be 1 only in AUTO; oState SHALL equal registered state.
REQ-012 Source selection: PLAYER uses iKey_*, AUTO uses iAuto_*, IDLE selects nothing (all requests zero).
REQ-013 Conflict: selected go and back both high SHALL yield neither; up and down both high SHALL yield neither; horizontal and vertical are independent.
REQ-014 Move strobes SHALL be registered, asserted exactly one cycle, on the edge following the cycle iFrame_tick is high, using the state and inputs sampled in that tick cycle.
REQ-015 No strobe SHALL assert in any cycle not following an iFrame_tick; at most one strobe set per frame.
REQ-016 Special timer: 8-bit or wider counter; iSpecial_hit loads SPECIAL_FRAMES; otherwise decrements on iFrame_tick when nonzero; holds at zero.
REQ-017 iSpecial_hit and iFrame_tick in the same cycle SHALL load (load wins; no decrement).
REQ-018 iSpecial_hit while timer nonzero SHALL reload SPECIAL_FRAMES (window extends, not accumulate).
REQ-019 oSpecial_block SHALL be registered and equal (timer != 0) one cycle after the counter update.
REQ-020 Special timer and FSM SHALL be independent; state changes SHALL NOT affect the timer.

Reset
REQ-021 iRST_n low at a rising edge SHALL set state IDLE, idle counter 0, special timer 0, all strobes 0, oSpecial_block 0, oOwner 0, oState 00.
REQ-022 Reset SHALL take priority over every other input, including mid-window and mid-AUTO; first post-reset strobe SHALL need a fresh iFrame_tick.

Verification
REQ-023 Reset, iKey_go held, ticks every 10 cycles -> state 01 after 1 edge; oSlider_go one-cycle pulse one cycle after each tick, nothing else.
REQ-024 IDLE_TIMEOUT=4, iAuto_en=1, keys released in PLAYER -> AUTO after 4th tick, oOwner=1; iKey_up pulse -> PLAYER next edge, oOwner=0.
REQ-025 In AUTO, iAuto_go and iAuto_back both high plus iAuto_down high at tick -> only oSlider_down pulses.
REQ-026 SPECIAL_FRAMES=3, iSpecial_hit -> oSpecial_block high; low after 3rd subsequent tick; hit coincident with a tick reloads to 3, no decrement.
REQ-027 AUTO with timer at 2, iRST_n low for one edge -> state 00, oSpecial_block 0, no strobe on the tick arriving in the reset cycle.
REQ-028 In AUTO, drop iAuto_en with keys idle -> state 00 next edge; subsequent ticks yield no strobes.

Source files
------------

// File: rtl/slider_move_ctrl.sv
// Slider movement arbiter: picks player or autopilot direction requests, emits one
// move strobe set per frame, and runs the special-block slow-move window timer.
module slider_move_ctrl #(
  parameter int SPECIAL_FRAMES = 180,
  parameter int IDLE_TIMEOUT   = 600
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iFrame_tick,
  input  logic       iKey_go,
  input  logic       iKey_back,
  input  logic       iKey_up,
  input  logic       iKey_down,
  input  logic       iAuto_en,
  input  logic       iAuto_go,
  input  logic       iAuto_back,
  input  logic       iAuto_up,
  input  logic       iAuto_down,
  input  logic       iSpecial_hit,
  output logic       oSlider_go,
  output logic       oSlider_back,
  output logic       oSlider_up,
  output logic       oSlider_down,
  output logic       oSpecial_block,
  output logic       oOwner,
  output logic [1:0] oState
);

  localparam int TIMER_W = ($clog2(SPECIAL_FRAMES + 1) > 8) ? $clog2(SPECIAL_FRAMES + 1) : 8;
  localparam logic [TIMER_W-1:0] SPECIAL_LOAD = TIMER_W'(SPECIAL_FRAMES);
  localparam logic [9:0]         IDLE_LIMIT   = 10'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PLAYER = 2'b01,
    AUTO   = 2'b10,
    BAD    = 2'b11
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [9:0]         idleCnt;
  logic [TIMER_W-1:0] specialTimer;
  logic               playerActive;
  logic               idleDone;
  logic               selGo;
  logic               selBack;
  logic               selUp;
  logic               selDown;
  logic               moveGo;
  logic               moveBack;
  logic               moveUp;
  logic               moveDown;

  assign playerActive = iKey_go | iKey_back | iKey_up | iKey_down;
  assign idleDone     = (idleCnt == IDLE_LIMIT);

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Player input overrides everything except recovery from the unused encoding.
  always_comb begin
    stateNext = state;
    if (state == BAD) begin
      stateNext = IDLE;
    end else if (playerActive) begin
      stateNext = PLAYER;
    end else begin
      case (state)
        IDLE:    if (idleDone && iAuto_en) stateNext = AUTO;
        PLAYER:  if (idleDone) stateNext = iAuto_en ? AUTO : IDLE;
        AUTO:    if (!iAuto_en) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Frames since the last key press, saturating at the handover limit.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      idleCnt <= '0;
    end else if (playerActive) begin
      idleCnt <= '0;
    end else if (iFrame_tick && (idleCnt < IDLE_LIMIT)) begin
      idleCnt <= idleCnt + 10'd1;
    end
  end

  always_comb begin
    selGo   = 1'b0;
    selBack = 1'b0;
    selUp   = 1'b0;
    selDown = 1'b0;
    case (state)
      PLAYER: begin
        selGo   = iKey_go;
        selBack = iKey_back;
        selUp   = iKey_up;
        selDown = iKey_down;
      end
      AUTO: begin
        selGo   = iAuto_go;
        selBack = iAuto_back;
        selUp   = iAuto_up;
        selDown = iAuto_down;
      end
      default: begin
        selGo   = 1'b0;
        selBack = 1'b0;
        selUp   = 1'b0;
        selDown = 1'b0;
      end
    endcase
  end

  // Opposing requests on one axis cancel; the two axes never interact.
  assign moveGo   = selGo   & ~selBack;
  assign moveBack = selBack & ~selGo;
  assign moveUp   = selUp   & ~selDown;
  assign moveDown = selDown & ~selUp;

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      oSlider_go   <= 1'b0;
      oSlider_back <= 1'b0;
      oSlider_up   <= 1'b0;
      oSlider_down <= 1'b0;
    end else if (iFrame_tick) begin
      oSlider_go   <= moveGo;
      oSlider_back <= moveBack;
      oSlider_up   <= moveUp;
      oSlider_down <= moveDown;
    end else begin
      oSlider_go   <= 1'b0;
      oSlider_back <= 1'b0;
      oSlider_up   <= 1'b0;
      oSlider_down <= 1'b0;
    end
  end

  // A hit always reloads the full window, even on a tick or mid-window.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      specialTimer   <= '0;
      oSpecial_block <= 1'b0;
    end else begin
      if (iSpecial_hit) begin
        specialTimer <= SPECIAL_LOAD;
      end else if (iFrame_tick && (specialTimer != '0)) begin
        specialTimer <= specialTimer - 1'b1;
      end
      oSpecial_block <= (specialTimer != '0);
    end
  end

  assign oOwner = (state == AUTO);
  assign oState = state;

endmodule

// File: tb/tb_slider_move_ctrl.sv
// Self-checking bench for slider_move_ctrl with a short idle timeout and special window.
module tb_slider_move_ctrl;

  localparam int SPECIAL_FRAMES = 3;
  localparam int IDLE_TIMEOUT   = 4;
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_PLAYER = 2'b01;
  localparam logic [1:0] S_AUTO   = 2'b10;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n;
  logic       iFrame_tick;
  logic       iKey_go, iKey_back, iKey_up, iKey_down;
  logic       iAuto_en;
  logic       iAuto_go, iAuto_back, iAuto_up, iAuto_down;
  logic       iSpecial_hit;
  logic       oSlider_go, oSlider_back, oSlider_up, oSlider_down;
  logic       oSpecial_block;
  logic       oOwner;
  logic [1:0] oState;
  logic [3:0] strobes;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  slider_move_ctrl #(
    .SPECIAL_FRAMES(SPECIAL_FRAMES),
    .IDLE_TIMEOUT  (IDLE_TIMEOUT)
  ) dut (
    .iVGA_CLK      (iVGA_CLK),
    .iRST_n        (iRST_n),
    .iFrame_tick   (iFrame_tick),
    .iKey_go       (iKey_go),
    .iKey_back     (iKey_back),
    .iKey_up       (iKey_up),
    .iKey_down     (iKey_down),
    .iAuto_en      (iAuto_en),
    .iAuto_go      (iAuto_go),
    .iAuto_back    (iAuto_back),
    .iAuto_up      (iAuto_up),
    .iAuto_down    (iAuto_down),
    .iSpecial_hit  (iSpecial_hit),
    .oSlider_go    (oSlider_go),
    .oSlider_back  (oSlider_back),
    .oSlider_up    (oSlider_up),
    .oSlider_down  (oSlider_down),
    .oSpecial_block(oSpecial_block),
    .oOwner        (oOwner),
    .oState        (oState)
  );

  assign strobes = {oSlider_go, oSlider_back, oSlider_up, oSlider_down};

  // clock / reset block
  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobes {go,back,up,down} given the state the DUT is in during the tick.
  function automatic logic [3:0] model_strobe(input logic [1:0] st);
    logic g, b, u, d;
    g = 1'b0; b = 1'b0; u = 1'b0; d = 1'b0;
    if (st == S_PLAYER) begin
      g = iKey_go; b = iKey_back; u = iKey_up; d = iKey_down;
    end else if (st == S_AUTO) begin
      g = iAuto_go; b = iAuto_back; u = iAuto_up; d = iAuto_down;
    end
    return {g & ~b, b & ~g, u & ~d, d & ~u};
  endfunction

  // One clock: optional tick; strobes are scored right after the following edge.
  task automatic clk_cycle(input logic tick, input logic [1:0] st);
    logic [3:0] exp;
    iFrame_tick = tick;
    if (tick) exp_q.push_back(iRST_n ? model_strobe(st) : 4'b0000);
    @(posedge iVGA_CLK);
    #1;
    iFrame_tick = 1'b0;
    if (tick) begin
      exp = exp_q.pop_front();
      check("strobe", 32'(strobes), 32'(exp));
    end else begin
      check("no_strobe", 32'(strobes), 32'd0);
    end
  endtask

  task automatic frame(input int gap, input logic [1:0] st);
    for (int i = 0; i < gap; i++) clk_cycle(1'b0, st);
    clk_cycle(1'b1, st);
  endtask

  initial begin
    iRST_n = 1'b0; iFrame_tick = 1'b0; iSpecial_hit = 1'b0;
    iKey_go = 1'b0; iKey_back = 1'b0; iKey_up = 1'b0; iKey_down = 1'b0;
    iAuto_en = 1'b0; iAuto_go = 1'b0; iAuto_back = 1'b0; iAuto_up = 1'b0; iAuto_down = 1'b0;

    // reset, including a tick while held in reset
    clk_cycle(1'b0, S_IDLE);
    clk_cycle(1'b1, S_IDLE);
    check("rst_state", 32'(oState), 32'(S_IDLE));
    check("rst_owner", 32'(oOwner), 32'd0);
    check("rst_special", 32'(oSpecial_block), 32'd0);
    iRST_n = 1'b1;
    clk_cycle(1'b0, S_IDLE);
    check("idle_state", 32'(oState), 32'(S_IDLE));

    // player go held, ticks every 10 cycles
    iKey_go = 1'b1;
    clk_cycle(1'b0, S_IDLE);
    check("player_entry", 32'(oState), 32'(S_PLAYER));
    for (int f = 0; f < 3; f++) frame(9, S_PLAYER);
    iKey_back = 1'b1; iKey_up = 1'b1;
    frame(2, S_PLAYER);
    iKey_go = 1'b0; iKey_back = 1'b0; iKey_up = 1'b0; iKey_down = 1'b1;
    frame(2, S_PLAYER);
    iKey_up = 1'b1;
    frame(1, S_PLAYER);
    iKey_up = 1'b0;

    // keys released with autopilot enabled: handover after the timeout
    iKey_down = 1'b0; iAuto_en = 1'b1;
    for (int f = 0; f < 3; f++) frame(2, S_PLAYER);
    check("pre_timeout", 32'(oState), 32'(S_PLAYER));
    frame(2, S_PLAYER);
    check("at_timeout", 32'(oState), 32'(S_PLAYER));
    clk_cycle(1'b0, S_PLAYER);
    check("auto_state", 32'(oState), 32'(S_AUTO));
    check("auto_owner", 32'(oOwner), 32'd1);

    // autopilot conflicts
    iAuto_go = 1'b1; iAuto_back = 1'b1; iAuto_down = 1'b1;
    frame(1, S_AUTO);
    iAuto_back = 1'b0; iAuto_down = 1'b0; iAuto_up = 1'b1;
    frame(1, S_AUTO);
    check("auto_hold", 32'(oState), 32'(S_AUTO));

    // player key pulse takes over
    iKey_up = 1'b1;
    clk_cycle(1'b0, S_AUTO);
    iKey_up = 1'b0;
    check("takeover_state", 32'(oState), 32'(S_PLAYER));
    check("takeover_owner", 32'(oOwner), 32'd0);
    iAuto_go = 1'b0; iAuto_up = 1'b0;

    // special window, kept in PLAYER by cancelling keys
    iKey_go = 1'b1; iKey_back = 1'b1;
    iSpecial_hit = 1'b1;
    clk_cycle(1'b0, S_PLAYER);
    iSpecial_hit = 1'b0;
    check("sp_lag", 32'(oSpecial_block), 32'd0);
    clk_cycle(1'b0, S_PLAYER);
    check("sp_on", 32'(oSpecial_block), 32'd1);
    frame(1, S_PLAYER);
    frame(1, S_PLAYER);
    check("sp_two_ticks", 32'(oSpecial_block), 32'd1);
    frame(1, S_PLAYER);
    check("sp_third_tick_lag", 32'(oSpecial_block), 32'd1);
    clk_cycle(1'b0, S_PLAYER);
    check("sp_off", 32'(oSpecial_block), 32'd0);

    iSpecial_hit = 1'b1;
    clk_cycle(1'b1, S_PLAYER);
    iSpecial_hit = 1'b0;
    clk_cycle(1'b0, S_PLAYER);
    check("sp_coinc_on", 32'(oSpecial_block), 32'd1);
    frame(1, S_PLAYER);
    frame(1, S_PLAYER);
    clk_cycle(1'b0, S_PLAYER);
    check("sp_coinc_no_dec", 32'(oSpecial_block), 32'd1);
    frame(1, S_PLAYER);
    clk_cycle(1'b0, S_PLAYER);
    check("sp_coinc_off", 32'(oSpecial_block), 32'd0);

    iSpecial_hit = 1'b1;
    clk_cycle(1'b0, S_PLAYER);
    iSpecial_hit = 1'b0;
    frame(1, S_PLAYER);
    iSpecial_hit = 1'b1;
    clk_cycle(1'b0, S_PLAYER);
    iSpecial_hit = 1'b0;
    frame(1, S_PLAYER);
    frame(1, S_PLAYER);
    clk_cycle(1'b0, S_PLAYER);
    check("sp_reload_on", 32'(oSpecial_block), 32'd1);
    frame(1, S_PLAYER);
    clk_cycle(1'b0, S_PLAYER);
    check("sp_reload_off", 32'(oSpecial_block), 32'd0);

    // back to AUTO, timer at 2, then reset with a coincident tick
    iKey_go = 1'b0; iKey_back = 1'b0;
    for (int f = 0; f < 4; f++) frame(1, S_PLAYER);
    clk_cycle(1'b0, S_PLAYER);
    check("auto_again", 32'(oState), 32'(S_AUTO));
    iSpecial_hit = 1'b1;
    clk_cycle(1'b0, S_AUTO);
    iSpecial_hit = 1'b0;
    frame(0, S_AUTO);
    check("pre_rst_special", 32'(oSpecial_block), 32'd1);
    iAuto_go = 1'b1; iRST_n = 1'b0;
    clk_cycle(1'b1, S_AUTO);
    iRST_n = 1'b1;
    check("mid_rst_state", 32'(oState), 32'(S_IDLE));
    check("mid_rst_special", 32'(oSpecial_block), 32'd0);
    check("mid_rst_owner", 32'(oOwner), 32'd0);
    clk_cycle(1'b0, S_IDLE);
    check("post_rst_special", 32'(oSpecial_block), 32'd0);

    // IDLE handover to AUTO, then drop autopilot enable
    for (int f = 0; f < 3; f++) frame(1, S_IDLE);
    check("idle_counting", 32'(oState), 32'(S_IDLE));
    frame(1, S_IDLE);
    check("idle_at_timeout", 32'(oState), 32'(S_IDLE));
    clk_cycle(1'b0, S_IDLE);
    check("idle_to_auto", 32'(oState), 32'(S_AUTO));
    frame(1, S_AUTO);
    iAuto_en = 1'b0;
    clk_cycle(1'b0, S_AUTO);
    check("auto_drop_state", 32'(oState), 32'(S_IDLE));
    check("auto_drop_owner", 32'(oOwner), 32'd0);
    for (int f = 0; f < 3; f++) frame(2, S_IDLE);
    check("idle_stays", 32'(oState), 32'(S_IDLE));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
